// File: rtl/instr_issue_ctrl_pkg.sv
// Shared definitions for the instruction issue controller:
// FSM state encoding, instruction field layout, widths and default legal-opcode mask.
package instr_issue_ctrl_pkg;

    // Widths shared with the register file and ALU
    localparam int OPC_W = 6;
    localparam int REG_W = 5;

    // Field positions inside the 32-bit instruction word
    localparam int OPC_LSB  = 0;
    localparam int SRC1_LSB = 6;
    localparam int SRC2_LSB = 11;
    localparam int DST_LSB  = 16;

    // Bits [FIELD_W-1:0] carry every decoded field; the rest are ignored
    localparam int FIELD_W = DST_LSB + REG_W;

    // Default legal opcodes: 1-8, 11, 12, 13, 15
    localparam logic [63:0] DEFAULT_LEGAL_MASK = 64'h0000_0000_0000_B9FE;

    // Wait-counter width covers PIPE_LAT-1 for PIPE_LAT up to 15
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ISSUE  = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field split of a latched instruction plus legality lookup.
// Ports: i_fields (instr bits [20:0]) -> o_opcode, o_src1, o_src2, o_dst, o_legal.
module instr_field_decode
    import instr_issue_ctrl_pkg::*;
#(
    parameter logic [63:0] LEGAL_MASK = DEFAULT_LEGAL_MASK
) (
    input  logic [FIELD_W-1:0] i_fields,
    output logic [OPC_W-1:0]   o_opcode,
    output logic [REG_W-1:0]   o_src1,
    output logic [REG_W-1:0]   o_src2,
    output logic [REG_W-1:0]   o_dst,
    output logic               o_legal
);

    logic [OPC_W-1:0] w_opcode;

    assign w_opcode = i_fields[OPC_LSB +: OPC_W];
    assign o_opcode = w_opcode;
    assign o_src1   = i_fields[SRC1_LSB +: REG_W];
    assign o_src2   = i_fields[SRC2_LSB +: REG_W];
    assign o_dst    = i_fields[DST_LSB +: REG_W];

    // One mask bit per possible 6-bit opcode
    assign o_legal  = LEGAL_MASK[w_opcode];

endmodule

// File: rtl/instr_issue_ctrl.sv
// Instruction decode/issue controller feeding the register file: accepts one
// instruction per handshake, strobes valid_opcode for legal ones, then drains.
// Ports: clk, rst (async, active high); instr_valid/instr_ready/instr handshake;
// valid_opcode, opcode, addr1..3 to RF/ALU; busy, done, illegal status;
// issued_cnt (wrapping), illegal_cnt (saturating).
module instr_issue_ctrl
    import instr_issue_ctrl_pkg::*;
#(
    parameter int          PIPE_LAT   = 2,
    parameter logic [63:0] LEGAL_MASK = DEFAULT_LEGAL_MASK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic             valid_opcode,
    output logic [OPC_W-1:0] opcode,
    output logic [REG_W-1:0] addr1,
    output logic [REG_W-1:0] addr2,
    output logic [REG_W-1:0] addr3,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [15:0]      issued_cnt,
    output logic [7:0]       illegal_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(PIPE_LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [FIELD_W-1:0] r_instr;
    logic [FIELD_W-1:0] w_instr_nxt;
    logic [WAIT_W-1:0]  r_wcnt;
    logic [WAIT_W-1:0]  w_wcnt_nxt;

    logic               r_ready;
    logic               r_valid_opc;
    logic               r_busy;
    logic               r_done;
    logic               r_illegal;
    logic [OPC_W-1:0]   r_opcode;
    logic [REG_W-1:0]   r_addr1;
    logic [REG_W-1:0]   r_addr2;
    logic [REG_W-1:0]   r_addr3;
    logic [15:0]        r_issued_cnt;
    logic [7:0]         r_illegal_cnt;

    logic               w_ready_nxt;
    logic               w_valid_opc_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_illegal_nxt;
    logic [OPC_W-1:0]   w_opcode_nxt;
    logic [REG_W-1:0]   w_addr1_nxt;
    logic [REG_W-1:0]   w_addr2_nxt;
    logic [REG_W-1:0]   w_addr3_nxt;
    logic [15:0]        w_issued_nxt;
    logic [7:0]         w_illegal_cnt_nxt;

    logic [OPC_W-1:0]   w_dec_opcode;
    logic [REG_W-1:0]   w_dec_src1;
    logic [REG_W-1:0]   w_dec_src2;
    logic [REG_W-1:0]   w_dec_dst;
    logic               w_dec_legal;
    logic               w_handshake;

    // Upper instruction bits carry no information for this block
    logic               w_unused_hi;
    assign w_unused_hi = ^instr[31:FIELD_W];

    assign w_handshake = instr_valid & r_ready;

    instr_field_decode #(
        .LEGAL_MASK (LEGAL_MASK)
    ) u_decode (
        .i_fields (r_instr),
        .o_opcode (w_dec_opcode),
        .o_src1   (w_dec_src1),
        .o_src2   (w_dec_src2),
        .o_dst    (w_dec_dst),
        .o_legal  (w_dec_legal)
    );

    // Next-state and next-output logic; every output is the registered
    // value of what the next state requires, so the pulses line up with
    // the state they belong to.
    always_comb begin
        w_state_nxt       = r_state;
        w_instr_nxt       = r_instr;
        w_wcnt_nxt        = r_wcnt;
        w_ready_nxt       = 1'b0;
        w_valid_opc_nxt   = 1'b0;
        w_busy_nxt        = 1'b1;
        w_done_nxt        = 1'b0;
        w_illegal_nxt     = 1'b0;
        w_opcode_nxt      = r_opcode;
        w_addr1_nxt       = r_addr1;
        w_addr2_nxt       = r_addr2;
        w_addr3_nxt       = r_addr3;
        w_issued_nxt      = r_issued_cnt;
        w_illegal_cnt_nxt = r_illegal_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (w_handshake) begin
                    w_instr_nxt = instr[FIELD_W-1:0];
                    w_state_nxt = S_DECODE;
                end else begin
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_DECODE: begin
                if (w_dec_legal) begin
                    w_state_nxt     = S_ISSUE;
                    w_valid_opc_nxt = 1'b1;
                    w_opcode_nxt    = w_dec_opcode;
                    w_addr1_nxt     = w_dec_src1;
                    w_addr2_nxt     = w_dec_src2;
                    w_addr3_nxt     = w_dec_dst;
                    w_issued_nxt    = r_issued_cnt + 16'd1;
                end else begin
                    w_state_nxt   = S_IDLE;
                    w_ready_nxt   = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_illegal_nxt = 1'b1;
                    if (r_illegal_cnt != 8'hFF) begin
                        w_illegal_cnt_nxt = r_illegal_cnt + 8'd1;
                    end
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_wcnt_nxt  = WAIT_INIT;
            end
            S_WAIT: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr       <= '0;
            r_wcnt        <= '0;
            r_ready       <= 1'b1;
            r_valid_opc   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
            r_opcode      <= '0;
            r_addr1       <= '0;
            r_addr2       <= '0;
            r_addr3       <= '0;
            r_issued_cnt  <= '0;
            r_illegal_cnt <= '0;
        end else begin
            r_instr       <= w_instr_nxt;
            r_wcnt        <= w_wcnt_nxt;
            r_ready       <= w_ready_nxt;
            r_valid_opc   <= w_valid_opc_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_illegal     <= w_illegal_nxt;
            r_opcode      <= w_opcode_nxt;
            r_addr1       <= w_addr1_nxt;
            r_addr2       <= w_addr2_nxt;
            r_addr3       <= w_addr3_nxt;
            r_issued_cnt  <= w_issued_nxt;
            r_illegal_cnt <= w_illegal_cnt_nxt;
        end
    end

    assign instr_ready  = r_ready;
    assign valid_opcode = r_valid_opc;
    assign busy         = r_busy;
    assign done         = r_done;
    assign illegal      = r_illegal;
    assign opcode       = r_opcode;
    assign addr1        = r_addr1;
    assign addr2        = r_addr2;
    assign addr3        = r_addr3;
    assign issued_cnt   = r_issued_cnt;
    assign illegal_cnt  = r_illegal_cnt;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed self-checking bench for instr_issue_ctrl (PIPE_LAT=2 and PIPE_LAT=1 builds).
module tb_instr_issue_ctrl;

    logic        clk;
    logic        rst;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        valid_opcode;
    logic [5:0]  opcode;
    logic [4:0]  addr1, addr2, addr3;
    logic        busy, done, illegal;
    logic [15:0] issued_cnt;
    logic [7:0]  illegal_cnt;

    logic        v2;
    logic        rdy2;
    logic [31:0] in2;
    logic        vo2;
    logic [5:0]  opc2;
    logic [4:0]  a1_2, a2_2, a3_2;
    logic        busy2, done2, ill2;
    logic [15:0] icnt2;
    logic [7:0]  lcnt2;

    int n_checks;
    int n_err;

    instr_issue_ctrl #(.PIPE_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .valid_opcode (valid_opcode),
        .opcode       (opcode),
        .addr1        (addr1),
        .addr2        (addr2),
        .addr3        (addr3),
        .busy         (busy),
        .done         (done),
        .illegal      (illegal),
        .issued_cnt   (issued_cnt),
        .illegal_cnt  (illegal_cnt)
    );

    instr_issue_ctrl #(.PIPE_LAT(1)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (v2),
        .instr_ready  (rdy2),
        .instr        (in2),
        .valid_opcode (vo2),
        .opcode       (opc2),
        .addr1        (a1_2),
        .addr2        (a2_2),
        .addr3        (a3_2),
        .busy         (busy2),
        .done         (done2),
        .illegal      (ill2),
        .issued_cnt   (icnt2),
        .illegal_cnt  (lcnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        v2 = 1'b0;
        in2 = '0;
        step();
        step();
        n_checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_busy got %b/%b exp 1/0", instr_ready, busy);
        end
        n_checks++;
        if ({valid_opcode, done, illegal} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_pulses got %b exp 000", {valid_opcode, done, illegal});
        end
        n_checks++;
        if ({opcode, addr1, addr2, addr3} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_fields got %h exp 0", {opcode, addr1, addr2, addr3});
        end
        n_checks++;
        if (issued_cnt !== 16'd0 || illegal_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_counts got %0d/%0d exp 0/0", issued_cnt, illegal_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_legal();
        instr_valid = 1'b1;
        instr = 32'h0000_3081;
        step();
        instr_valid = 1'b0;
        instr = '0;
        n_checks++;
        if ({instr_ready, busy, valid_opcode} !== 3'b010) begin
            n_err++;
            $display("FAIL legal_accept rdy/busy/vo got %b exp 010", {instr_ready, busy, valid_opcode});
        end
        step();
        n_checks++;
        if (valid_opcode !== 1'b1) begin
            n_err++;
            $display("FAIL legal_strobe got %b exp 1", valid_opcode);
        end
        n_checks++;
        if (opcode !== 6'd1 || addr1 !== 5'd2 || addr2 !== 5'd6 || addr3 !== 5'd0) begin
            n_err++;
            $display("FAIL legal_fields got %0d %0d %0d %0d exp 1 2 6 0", opcode, addr1, addr2, addr3);
        end
        n_checks++;
        if (issued_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL legal_issued_cnt got %0d exp 1", issued_cnt);
        end
        step();
        n_checks++;
        if (valid_opcode !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL legal_strobe_end vo/busy got %b/%b exp 0/1", valid_opcode, busy);
        end
        // garbage on instr with valid during WAIT must not disturb anything
        instr_valid = 1'b1;
        instr = 32'hFFFF_FFFF;
        step();
        n_checks++;
        if (done !== 1'b0 || instr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL legal_wait done/rdy got %b/%b exp 0/0", done, instr_ready);
        end
        n_checks++;
        if (opcode !== 6'd1 || addr1 !== 5'd2 || addr2 !== 5'd6 || addr3 !== 5'd0) begin
            n_err++;
            $display("FAIL wait_addr_stable got %0d %0d %0d %0d exp 1 2 6 0", opcode, addr1, addr2, addr3);
        end
        instr_valid = 1'b0;
        instr = '0;
        step();
        n_checks++;
        if ({done, instr_ready, busy, illegal} !== 4'b1100) begin
            n_err++;
            $display("FAIL legal_done done/rdy/busy/ill got %b exp 1100", {done, instr_ready, busy, illegal});
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL legal_done_width got %b exp 0", done);
        end
    endtask

    task automatic test_illegal();
        instr_valid = 1'b1;
        instr = 32'h0000_0009;
        step();
        instr_valid = 1'b0;
        instr = '0;
        step();
        n_checks++;
        if ({illegal, instr_ready, busy, valid_opcode, done} !== 5'b11000) begin
            n_err++;
            $display("FAIL illegal_pulse ill/rdy/busy/vo/done got %b exp 11000",
                     {illegal, instr_ready, busy, valid_opcode, done});
        end
        n_checks++;
        if (illegal_cnt !== 8'd1 || issued_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL illegal_counts got %0d/%0d exp 1/1", illegal_cnt, issued_cnt);
        end
        n_checks++;
        if (opcode !== 6'd1 || addr1 !== 5'd2 || addr2 !== 5'd6) begin
            n_err++;
            $display("FAIL illegal_fields_kept got %0d %0d %0d exp 1 2 6", opcode, addr1, addr2);
        end
        step();
        n_checks++;
        if (illegal !== 1'b0 || valid_opcode !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_width ill/vo got %b/%b exp 0/0", illegal, valid_opcode);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        logic [20:0] exp_f [3];
        int k;
        int ns;
        int last;
        logic acc;
        words[0] = 32'h0005_20C2;
        words[1] = 32'h001F_07CF;
        words[2] = 32'hFFE9_884D;
        exp_f[0] = {6'd2, 5'd3, 5'd4, 5'd5};
        exp_f[1] = {6'd15, 5'd31, 5'd0, 5'd31};
        exp_f[2] = {6'd13, 5'd1, 5'd17, 5'd9};
        k = 0;
        ns = 0;
        last = 0;
        instr_valid = 1'b1;
        instr = words[0];
        for (int i = 0; i < 40; i++) begin
            acc = instr_ready & instr_valid;
            step();
            if (acc) begin
                k++;
                if (k < 3) instr = words[k];
                else instr_valid = 1'b0;
            end
            if (valid_opcode === 1'b1) begin
                if (ns < 3) begin
                    n_checks++;
                    if ({opcode, addr1, addr2, addr3} !== exp_f[ns]) begin
                        n_err++;
                        $display("FAIL b2b_fields[%0d] got %h exp %h", ns,
                                 {opcode, addr1, addr2, addr3}, exp_f[ns]);
                    end
                end
                if (ns > 0) begin
                    n_checks++;
                    if (i - last !== 5) begin
                        n_err++;
                        $display("FAIL b2b_spacing[%0d] got %0d exp 5", ns, i - last);
                    end
                end
                last = i;
                ns++;
            end
        end
        n_checks++;
        if (ns !== 3) begin
            n_err++;
            $display("FAIL b2b_strobe_count got %0d exp 3", ns);
        end
        n_checks++;
        if (issued_cnt !== 16'd4) begin
            n_err++;
            $display("FAIL b2b_issued_cnt got %0d exp 4", issued_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int np;
        instr_valid = 1'b1;
        instr = 32'h0005_20C2;
        step();
        instr_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({instr_ready, busy, valid_opcode, done, illegal} !== 5'b10000) begin
            n_err++;
            $display("FAIL rst_mid_outputs got %b exp 10000",
                     {instr_ready, busy, valid_opcode, done, illegal});
        end
        n_checks++;
        if (issued_cnt !== 16'd0 || illegal_cnt !== 8'd0 || opcode !== 6'd0) begin
            n_err++;
            $display("FAIL rst_mid_state got %0d/%0d/%0d exp 0/0/0", issued_cnt, illegal_cnt, opcode);
        end
        #2;
        rst = 1'b0;
        np = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1 || valid_opcode === 1'b1) np++;
        end
        n_checks++;
        if (np !== 0 || instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_after pulses/rdy got %0d/%b exp 0/1", np, instr_ready);
        end
    endtask

    task automatic test_saturate();
        int nacc;
        int nvo;
        logic acc;
        nacc = 0;
        nvo = 0;
        instr_valid = 1'b1;
        instr = 32'h0000_0000;
        for (int i = 0; i < 600; i++) begin
            if (nacc == 256) break;
            acc = instr_ready & instr_valid;
            step();
            if (acc) nacc++;
            if (valid_opcode === 1'b1) nvo++;
        end
        instr_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (nacc !== 256) begin
            n_err++;
            $display("FAIL sat_accepts got %0d exp 256", nacc);
        end
        n_checks++;
        if (illegal_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_illegal_cnt got %0d exp 255", illegal_cnt);
        end
        n_checks++;
        if (nvo !== 0 || issued_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL sat_no_issue got %0d/%0d exp 0/0", nvo, issued_cnt);
        end
    endtask

    task automatic test_pipe_lat1();
        v2 = 1'b1;
        in2 = 32'h0005_20C2;
        step();
        v2 = 1'b0;
        in2 = '0;
        step();
        n_checks++;
        if (vo2 !== 1'b1 || opc2 !== 6'd2 || a3_2 !== 5'd5) begin
            n_err++;
            $display("FAIL lat1_strobe vo/opc/dst got %b/%0d/%0d exp 1/2/5", vo2, opc2, a3_2);
        end
        step();
        n_checks++;
        if (done2 !== 1'b0 || vo2 !== 1'b0) begin
            n_err++;
            $display("FAIL lat1_early_done done/vo got %b/%b exp 0/0", done2, vo2);
        end
        step();
        n_checks++;
        if (done2 !== 1'b1 || rdy2 !== 1'b1 || icnt2 !== 16'd1) begin
            n_err++;
            $display("FAIL lat1_done done/rdy/cnt got %b/%b/%0d exp 1/1/1", done2, rdy2, icnt2);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err = 0;
        test_reset();
        test_legal();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_pipe_lat1();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
